// File: rtl/processor_pkg.sv
// Shared constants and types for the processor control path.
//  - Opcode class codes (top bits of the opcode word).
//  - Sequencer state encoding; the values are visible on state_out.
//  - Decoded class bundle produced by opclass_decode.
package processor_pkg;

    localparam int unsigned ClsAlu  = 4'h1;
    localparam int unsigned ClsRom  = 4'h3;
    localparam int unsigned ClsRam  = 4'h4;
    localparam int unsigned ClsPc   = 4'h7;
    localparam int unsigned ClsHalt = 4'hF;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StDecode  = 3'd2,
        StExec    = 3'd3,
        StMemWait = 3'd4,
        StAdvance = 3'd5,
        StHalted  = 3'd6
    } state_e;

    typedef struct packed {
        logic alu;
        logic rom;
        logic ram;
        logic pc;
        logic halt;
        logic illegal;
    } opclass_t;

endpackage

// File: rtl/opclass_decode.sv
// Combinational opcode-class decoder.
//  cls_i    in   CLASS_W    opcode class field
//  class_o  out  opclass_t  one-hot class, illegal set for any unknown code
module opclass_decode
    import processor_pkg::*;
#(
    parameter int unsigned CLASS_W = 4
) (
    input  logic [CLASS_W-1:0] cls_i,
    output opclass_t           class_o
);

    always_comb begin
        class_o = '0;
        if (cls_i == CLASS_W'(ClsAlu)) begin
            class_o.alu = 1'b1;
        end else if (cls_i == CLASS_W'(ClsRom)) begin
            class_o.rom = 1'b1;
        end else if (cls_i == CLASS_W'(ClsRam)) begin
            class_o.ram = 1'b1;
        end else if (cls_i == CLASS_W'(ClsPc)) begin
            class_o.pc = 1'b1;
        end else if (cls_i == CLASS_W'(ClsHalt)) begin
            class_o.halt = 1'b1;
        end else begin
            class_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/fde_sequencer.sv
// Fetch-decode-execute control sequencer.
//  Inputs : clk, reset (async, active-high), run_en, step_mode, step_req,
//           rom_opcode/rom_operand (ROM word at PC), ram_ack.
//  Outputs: pc_read_enable, pc_enable, alu_read_enable, ram_read_enable, ram_req,
//           ir_opcode/ir_operand (latched instruction), state_out, halted,
//           illegal_op and mem_timeout (sticky), instr_count (retired, wrapping).
module fde_sequencer
    import processor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned CLASS_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_en,
    input  logic                  step_mode,
    input  logic                  step_req,
    input  logic [DATA_WIDTH-1:0] rom_opcode,
    input  logic [DATA_WIDTH-1:0] rom_operand,
    input  logic                  ram_ack,
    output logic                  pc_read_enable,
    output logic                  pc_enable,
    output logic                  alu_read_enable,
    output logic                  ram_read_enable,
    output logic                  ram_req,
    output logic [DATA_WIDTH-1:0] ir_opcode,
    output logic [DATA_WIDTH-1:0] ir_operand,
    output logic [2:0]            state_out,
    output logic                  halted,
    output logic                  illegal_op,
    output logic                  mem_timeout,
    output logic [CNT_WIDTH-1:0]  instr_count
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_opcode_q, ir_opcode_d;
    logic [DATA_WIDTH-1:0] ir_operand_q, ir_operand_d;
    logic                  illegal_q, illegal_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [WaitW-1:0]      wait_q, wait_d;
    opclass_t              opclass;

    opclass_decode #(
        .CLASS_W (CLASS_W)
    ) u_opclass_decode (
        .cls_i   (ir_opcode_q[DATA_WIDTH-1 -: CLASS_W]),
        .class_o (opclass)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            ir_opcode_q  <= '0;
            ir_operand_q <= '0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= '0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            ir_opcode_q  <= ir_opcode_d;
            ir_operand_q <= ir_operand_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
            count_q      <= count_d;
            wait_q       <= wait_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ir_opcode_d     = ir_opcode_q;
        ir_operand_d    = ir_operand_q;
        illegal_d       = illegal_q;
        timeout_d       = timeout_q;
        count_d         = count_q;
        wait_d          = wait_q;
        pc_read_enable  = 1'b0;
        pc_enable       = 1'b0;
        alu_read_enable = 1'b0;
        ram_read_enable = 1'b0;
        ram_req         = 1'b0;
        halted          = 1'b0;

        case (state_q)
            StIdle: begin
                if (step_mode ? step_req : run_en) state_d = StFetch;
            end
            StFetch: begin
                pc_read_enable = 1'b1;
                ir_opcode_d    = rom_opcode;
                ir_operand_d   = rom_operand;
                state_d        = StDecode;
            end
            StDecode: begin
                state_d = StExec;
            end
            StExec: begin
                wait_d  = '0;
                state_d = StAdvance;
                if (opclass.halt) begin
                    state_d = StHalted;
                end else if (opclass.alu) begin
                    alu_read_enable = 1'b1;
                end else if (opclass.ram) begin
                    ram_req = 1'b1;
                    // Zero-wait RAM completes straight from EXEC.
                    if (ram_ack) ram_read_enable = 1'b1;
                    else         state_d = StMemWait;
                end else if (opclass.illegal) begin
                    illegal_d = 1'b1;
                end
            end
            StMemWait: begin
                ram_req = 1'b1;
                wait_d  = wait_q + WaitW'(1);
                if (ram_ack) begin
                    ram_read_enable = 1'b1;
                    state_d         = StAdvance;
                end else if (wait_q == WaitW'(MEM_TIMEOUT - 1)) begin
                    // wait_q counts completed wait cycles, so this is cycle MEM_TIMEOUT.
                    timeout_d = 1'b1;
                    state_d   = StHalted;
                end
            end
            StAdvance: begin
                pc_enable = 1'b1;
                count_d   = count_q + CNT_WIDTH'(1);
                if (step_mode)   state_d = StIdle;
                else if (run_en) state_d = StFetch;
                else             state_d = StIdle;
            end
            StHalted: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ir_opcode   = ir_opcode_q;
    assign ir_operand  = ir_operand_q;
    assign state_out   = state_q;
    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_fde_sequencer.sv
// Directed self-checking bench for fde_sequencer.
module tb_fde_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_en;
    logic        step_mode;
    logic        step_req;
    logic [15:0] rom_opcode;
    logic [15:0] rom_operand;
    logic        ram_ack;
    logic        pc_read_enable;
    logic        pc_enable;
    logic        alu_read_enable;
    logic        ram_read_enable;
    logic        ram_req;
    logic [15:0] ir_opcode;
    logic [15:0] ir_operand;
    logic [2:0]  state_out;
    logic        halted;
    logic        illegal_op;
    logic        mem_timeout;
    logic [31:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fde_sequencer #(
        .DATA_WIDTH  (16),
        .CLASS_W     (4),
        .MEM_TIMEOUT (15),
        .CNT_WIDTH   (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .run_en          (run_en),
        .step_mode       (step_mode),
        .step_req        (step_req),
        .rom_opcode      (rom_opcode),
        .rom_operand     (rom_operand),
        .ram_ack         (ram_ack),
        .pc_read_enable  (pc_read_enable),
        .pc_enable       (pc_enable),
        .alu_read_enable (alu_read_enable),
        .ram_read_enable (ram_read_enable),
        .ram_req         (ram_req),
        .ir_opcode       (ir_opcode),
        .ir_operand      (ir_operand),
        .state_out       (state_out),
        .halted          (halted),
        .illegal_op      (illegal_op),
        .mem_timeout     (mem_timeout),
        .instr_count     (instr_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enables packed as {pc_read, pc_en, alu_read, ram_read, ram_req}.
    function automatic logic [4:0] enables();
        return {pc_read_enable, pc_enable, alu_read_enable, ram_read_enable, ram_req};
    endfunction

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_state", state_out, 3'd0);
        check_eq("rst_enables", enables(), 5'b0);
        check_eq("rst_flags", {halted, illegal_op, mem_timeout}, 3'b0);
        check_eq("rst_count", instr_count, 32'd0);
        check_eq("rst_ir", {ir_opcode, ir_operand}, 32'd0);
        tick();
        reset = 1'b0;
    endtask

    // Start one free-run instruction from IDLE and stop after it.
    task automatic start_one(input logic [15:0] op);
        rom_opcode = op;
        run_en     = 1'b1;
        tick();               // FETCH
        run_en     = 1'b0;
    endtask

    initial begin
        logic [2:0] seq_exp [5];
        logic       bad;
        logic       pc_seen;
        reset     = 1'b0;
        run_en    = 1'b0;
        step_mode = 1'b0;
        step_req  = 1'b0;
        rom_opcode  = 16'h1234;
        rom_operand = 16'hABCD;
        ram_ack   = 1'b0;
        #3;
        do_reset();

        // 1: ALU op free-running, state 1,2,3,5,1.
        seq_exp = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        run_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("alu_state%0d", i), state_out, seq_exp[i]);
            case (i)
                0: check_eq("alu_fetch_en", enables(), 5'b10000);
                1: check_eq("alu_ir", {ir_opcode, ir_operand}, 32'h1234ABCD);
                2: check_eq("alu_exec_en", enables(), 5'b00100);
                3: check_eq("alu_adv_en", enables(), 5'b01000);
                4: check_eq("alu_count1", instr_count, 32'd1);
                default: ;
            endcase
        end
        run_en = 1'b0;           // mid-instruction: it must still complete
        tick(); tick(); tick();
        check_eq("alu_adv2", state_out, 3'd5);
        tick();
        check_eq("alu_stop_idle", state_out, 3'd0);
        check_eq("alu_count2", instr_count, 32'd2);

        // 2: RAM op, ack on 3rd MEM_WAIT cycle.
        start_one(16'h4010);
        tick();                  // DECODE
        tick();                  // EXEC
        check_eq("ram_exec", {state_out, enables()}, {3'd3, 5'b00001});
        tick();
        check_eq("ram_wait1", {state_out, enables()}, {3'd4, 5'b00001});
        tick();
        check_eq("ram_wait2", {state_out, enables()}, {3'd4, 5'b00001});
        tick();
        ram_ack = 1'b1;
        #1;
        check_eq("ram_wait3_ack", {state_out, enables()}, {3'd4, 5'b00011});
        tick();
        ram_ack = 1'b0;
        check_eq("ram_adv", {state_out, enables()}, {3'd5, 5'b01000});
        tick();
        check_eq("ram_count", instr_count, 32'd3);

        // 3: RAM op with no ack times out after 15 wait cycles.
        start_one(16'h4010);
        tick(); tick();          // DECODE, EXEC
        tick();                  // MEM_WAIT cycle 1
        bad = 1'b0;
        pc_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (state_out != 3'd4 || ram_req != 1'b1 || mem_timeout != 1'b0) bad = 1'b1;
            if (pc_enable) pc_seen = 1'b1;
            tick();
        end
        check_eq("to_wait_cycles", bad, 1'b0);
        check_eq("to_state", state_out, 3'd6);
        check_eq("to_flags", {mem_timeout, halted, ram_req}, 3'b110);
        check_eq("to_no_pc", pc_seen, 1'b0);
        check_eq("to_count", instr_count, 32'd3);
        do_reset();

        // 4: HALT.
        start_one(16'hF000);
        tick(); tick();          // DECODE, EXEC
        check_eq("halt_exec_en", enables(), 5'b0);
        tick();
        check_eq("halt_state", {state_out, halted}, {3'd6, 1'b1});
        run_en = 1'b1;
        step_req = 1'b1;
        tick(); tick();
        step_req = 1'b0;
        tick();
        check_eq("halt_sticky", {state_out, halted, enables()}, {3'd6, 1'b1, 5'b0});
        check_eq("halt_count", instr_count, 32'd0);
        run_en = 1'b0;
        do_reset();

        // 5: illegal class skipped, next instruction normal.
        start_one(16'h2000);
        run_en = 1'b1;
        tick(); tick();          // DECODE, EXEC
        check_eq("ill_exec", {state_out, illegal_op}, {3'd3, 1'b0});
        tick();
        check_eq("ill_adv", {state_out, pc_enable, illegal_op}, {3'd5, 1'b1, 1'b1});
        rom_opcode = 16'h1234;
        tick();
        check_eq("ill_next_fetch", state_out, 3'd1);
        run_en = 1'b0;
        tick();
        check_eq("ill_next_ir", {ir_opcode, illegal_op}, {16'h1234, 1'b1});
        tick();
        check_eq("ill_next_alu", alu_read_enable, 1'b1);
        tick(); tick();
        check_eq("ill_count", {state_out, instr_count}, {3'd0, 32'd2});
        do_reset();

        // 6: single-step, run_en ignored in step mode, mid-instruction step_req dropped.
        step_mode = 1'b1;
        run_en    = 1'b1;
        tick(); tick();
        check_eq("step_idle_wait", state_out, 3'd0);
        for (int k = 0; k < 3; k++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            check_eq($sformatf("step%0d_fetch", k), state_out, 3'd1);
            step_req = 1'b1;     // pulse during DECODE, must not be queued
            tick();
            step_req = 1'b0;
            tick(); tick(); tick();
            check_eq($sformatf("step%0d_idle", k), state_out, 3'd0);
            tick();
            check_eq($sformatf("step%0d_stay", k), state_out, 3'd0);
        end
        check_eq("step_count", instr_count, 32'd3);
        step_mode = 1'b0;
        run_en    = 1'b0;

        // Reset asynchronously in MEM_WAIT.
        start_one(16'h4010);
        tick(); tick(); tick();  // DECODE, EXEC, MEM_WAIT
        check_eq("arst_pre", {state_out, ram_req}, {3'd4, 1'b1});
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_state", {state_out, ram_req}, {3'd0, 1'b0});
        check_eq("arst_count", instr_count, 32'd0);
        tick();
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
